// File: rtl/input_debouncer.sv
// ---------------------------------------------------------------------------------------------
// input_debouncer
//
// Input conditioning stage in front of the chip_core counter. Each of WIDTH raw pad inputs is
// brought into the clk domain through a SYNC_STAGES-deep flop chain and then filtered: a
// channel only changes its debounced level after the synchronised input has disagreed with it
// for thr consecutive cycles, where thr = cfg_threshold (0 is treated as 1). Any single cycle
// of agreement restarts the count, so bounce and glitches are rejected. stable_o[0] and
// rise_o[0] replace raw ui_in[0] as the counter's count-enable.
//
// Optional feature (macro DEBOUNCE_STICKY_EN):
//   defined   - evt_o holds a sticky per-channel rise flag, cleared by writing 1 to clr_i.
//               A rise and a clear in the same cycle leave the flag set.
//   undefined - evt_o is tied to 0, clr_i is ignored and no sticky flops exist.
//
// Parameters:
//   WIDTH        number of independent input channels
//   CNT_W        width of each bounce counter and of cfg_threshold
//   SYNC_STAGES  synchroniser depth, 2..4
//
// Ports:
//   clk            single clock, all state on posedge
//   rst_n          asynchronous active-low reset
//   raw_i          asynchronous pad inputs
//   cfg_threshold  consecutive mismatch cycles needed to accept a change (0 acts as 1)
//   stable_o       debounced level per channel
//   rise_o         one-cycle pulse when stable_o goes 0->1
//   fall_o         one-cycle pulse when stable_o goes 1->0
//   clr_i          write-1-to-clear for evt_o
//   evt_o          sticky rise flags
// ---------------------------------------------------------------------------------------------

module input_debouncer #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw_i,
  input  logic [CNT_W-1:0] cfg_threshold,
  output logic [WIDTH-1:0] stable_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  input  logic [WIDTH-1:0] clr_i,
  output logic [WIDTH-1:0] evt_o
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : gen_bad_sync_stages
    $error("input_debouncer: SYNC_STAGES must be in 2..4");
  end

  // -------------------------------------------------------------------------------------------
  // Synchroniser: a plain shift chain, nothing between the stages.
  // -------------------------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0]                  sync_s;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], raw_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  // -------------------------------------------------------------------------------------------
  // Threshold. Comparing the counter against thr-1 with >= means a threshold lowered below the
  // current count takes effect on the very next mismatch cycle, and the counter can never run
  // past thr-1, so it cannot wrap even at the largest threshold.
  // -------------------------------------------------------------------------------------------
  logic [CNT_W-1:0] thr_m1;

  always_comb begin
    thr_m1 = '0;
    if (cfg_threshold != '0) begin
      thr_m1 = cfg_threshold - CNT_W'(1);
    end
  end

  // -------------------------------------------------------------------------------------------
  // Per-channel filter
  // -------------------------------------------------------------------------------------------
  for (genvar g = 0; g < WIDTH; g++) begin : gen_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      if (sync_s[g] == stable_q) begin
        // Agreement, even for one cycle, discards any partial count.
        cnt_d = '0;
      end else if (cnt_q >= thr_m1) begin
        stable_d = sync_s[g];
        cnt_d    = '0;
        rise_d   = sync_s[g];
        fall_d   = ~sync_s[g];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q    <= '0;
        stable_q <= 1'b0;
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        stable_q <= stable_d;
        rise_q   <= rise_d;
        fall_q   <= fall_d;
      end
    end

    assign stable_o[g] = stable_q;
    assign rise_o[g]   = rise_q;
    assign fall_o[g]   = fall_q;
  end

  // -------------------------------------------------------------------------------------------
  // Sticky rise flags
  // -------------------------------------------------------------------------------------------
`ifdef DEBOUNCE_STICKY_EN
  logic [WIDTH-1:0] evt_q, evt_d;

  // Set term is OR-ed in last so a rise beats a simultaneous clear.
  always_comb begin
    evt_d = (evt_q & ~clr_i) | rise_o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_q <= '0;
    end else begin
      evt_q <= evt_d;
    end
  end

  assign evt_o = evt_q;
`else
  logic unused_clr;

  assign unused_clr = ^clr_i;
  assign evt_o      = '0;
`endif

endmodule
